// File: rtl/regfile_sequencer.sv
// regfile_sequencer: four-cycle IDLE/READ/EXEC/WRITE sequencer that drives a 2-read/1-write register file.
// Optional feature macro REGFILE_SEQUENCER_FLAGS_EN adds the flag_c/flag_z outputs and the ADC/SBC opcodes.
module regfile_sequencer #(
  parameter int DW  = 8,
  parameter int SW  = 4,
  parameter int OPW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [SW-1:0] asel,
  output logic [SW-1:0] bsel,
  input  logic [DW-1:0] aout,
  input  logic [DW-1:0] bout,
  output logic          cload,
  output logic [SW-1:0] csel,
  output logic [DW-1:0] cin,
  output logic          busy,
  output logic          done,
  output logic          err,
`ifdef REGFILE_SEQUENCER_FLAGS_EN
  output logic [DW-1:0] result,
  output logic          flag_c,
  output logic          flag_z
`else
  output logic [DW-1:0] result
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_MOV = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_AND = OPW'(4);
  localparam logic [OPW-1:0] OP_OR  = OPW'(5);
  localparam logic [OPW-1:0] OP_XOR = OPW'(6);
  localparam logic [OPW-1:0] OP_LDI = OPW'(7);
`ifdef REGFILE_SEQUENCER_FLAGS_EN
  localparam logic [OPW-1:0] OP_ADC = OPW'(8);
  localparam logic [OPW-1:0] OP_SBC = OPW'(9);
`endif

  state_t        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [DW-1:0] result_q, result_d;
  logic          err_q, err_d, wr_q, wr_d;

  logic [OPW-1:0] op_w;
  logic [SW-1:0]  c_w, a_w, b_w;
  logic           legal, writes, rd_a, rd_b;
  logic [DW-1:0]  res;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
  logic [DW:0]    sum_w;
  logic           upd;
  logic           flag_c_q, flag_c_d, flag_z_q, flag_z_d;
`endif

  assign op_w = instr_q[15:12];
  assign c_w  = instr_q[11:8];
  assign a_w  = instr_q[7:4];
  assign b_w  = instr_q[3:0];

  // Decode and ALU act on the latched instruction; the result is only captured in EXEC.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    legal  = 1'b1;
    writes = 1'b1;
    rd_a   = 1'b0;
    rd_b   = 1'b0;
    res    = '0;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    sum_w  = '0;
    upd    = 1'b0;
`endif
    case (op_w)
      OP_NOP: writes = 1'b0;
      OP_MOV: begin rd_a = 1'b1; res = opa_q; end
`ifdef REGFILE_SEQUENCER_FLAGS_EN
      OP_ADD: begin rd_a = 1'b1; rd_b = 1'b1; upd = 1'b1; sum_w = {1'b0, opa_q} + {1'b0, opb_q}; end
      OP_SUB: begin rd_a = 1'b1; rd_b = 1'b1; upd = 1'b1; sum_w = {1'b0, opa_q} - {1'b0, opb_q}; end
      OP_ADC: begin
        rd_a = 1'b1; rd_b = 1'b1; upd = 1'b1;
        sum_w = {1'b0, opa_q} + {1'b0, opb_q} + {{DW{1'b0}}, flag_c_q};
      end
      OP_SBC: begin
        rd_a = 1'b1; rd_b = 1'b1; upd = 1'b1;
        sum_w = {1'b0, opa_q} - {1'b0, opb_q} - {{DW{1'b0}}, flag_c_q};
      end
`else
      OP_ADD: begin rd_a = 1'b1; rd_b = 1'b1; res = opa_q + opb_q; end
      OP_SUB: begin rd_a = 1'b1; rd_b = 1'b1; res = opa_q - opb_q; end
`endif
      OP_AND: begin rd_a = 1'b1; rd_b = 1'b1; res = opa_q & opb_q; end
      OP_OR:  begin rd_a = 1'b1; rd_b = 1'b1; res = opa_q | opb_q; end
      OP_XOR: begin rd_a = 1'b1; rd_b = 1'b1; res = opa_q ^ opb_q; end
      OP_LDI: res = instr_q[7:0];
      default: begin legal = 1'b0; writes = 1'b0; end
    endcase
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    if (upd) res = sum_w[DW-1:0];
`endif
    // Selects 8..15 do not exist; only fields the opcode actually uses are policed.
    if ((writes && c_w[SW-1]) || (rd_a && a_w[SW-1]) || (rd_b && b_w[SW-1])) legal = 1'b0;
    if (!legal) begin
      res    = '0;
      writes = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    err_d    = err_q;
    wr_d     = wr_q;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
`endif
    case (state_q)
      IDLE: if (instr_valid) begin
        instr_d = instr;
        state_d = READ;
      end
      READ: begin
        opa_d   = aout;
        opb_d   = bout;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = res;
        err_d    = !legal;
        wr_d     = writes;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
        if (upd && legal) begin
          flag_c_d = sum_w[DW];
          flag_z_d = (res == '0);
        end
`endif
        state_d  = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q  <= state_d;
      instr_q  <= instr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
`endif
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  assign busy        = (state_q != IDLE);
  assign instr_ready = !busy;
  assign asel        = (state_q == READ) ? a_w : '0;
  assign bsel        = (state_q == READ) ? b_w : '0;
  assign done        = (state_q == WRITE);
  assign err         = done && err_q;
  assign cload       = done && wr_q;
  assign csel        = cload ? c_w : '0;
  assign cin         = cload ? result_q : '0;
  assign result      = result_q;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: directed instruction stream against a behavioural 2R1W register file.
// Define REGFILE_SEQUENCER_FLAGS_EN to also build and check the flag outputs and the ADC opcode.
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready;
  logic [15:0] instr;
  logic [3:0] asel, bsel, csel;
  logic [7:0] aout, bout, cin, result;
  logic       cload, busy, done, err;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
  logic       flag_c, flag_z;
`endif

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .asel(asel), .bsel(bsel), .aout(aout), .bout(bout),
    .cload(cload), .csel(csel), .cin(cin),
    .busy(busy), .done(done), .err(err),
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    .result(result), .flag_c(flag_c), .flag_z(flag_z)
`else
    .result(result)
`endif
  );

  // Behavioural register file: combinational reads, write on the clock edge.
  logic [7:0] rf [16];
  assign aout = rf[asel];
  assign bout = rf[bsel];
  always @(posedge clk) if (cload) rf[csel] <= cin;

  typedef struct {
    logic [15:0] ins;
    logic        cl;
    logic [3:0]  cs;
    logic [7:0]  ci;
    logic        er;
    logic [7:0]  res;
    logic        chk_res;
    logic        fc;
    logic        fz;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   prev_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] ins, input logic cl, input logic [3:0] cs,
                              input logic [7:0] ci, input logic er, input logic [7:0] res,
                              input logic chk_res, input logic fc, input logic fz);
    vec_t v;
    v.ins = ins; v.cl = cl; v.cs = cs; v.ci = ci; v.er = er;
    v.res = res; v.chk_res = chk_res; v.fc = fc; v.fz = fz;
    return v;
  endfunction

  // Monitor: every done pops one expectation; done arrives two edges after the accept edge
  // (the accept cycle plus READ and EXEC), i.e. during the third cycle after acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending instruction (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          check("cload", 32'(cload), 32'(mon_e.v.cl));
          check("csel", 32'(csel), 32'(mon_e.v.cs));
          check("cin", 32'(cin), 32'(mon_e.v.ci));
          check("err", 32'(err), 32'(mon_e.v.er));
          if (mon_e.v.chk_res) check("result", 32'(result), 32'(mon_e.v.res));
          check("done_latency", 32'(cyc - mon_e.acc), 32'd2);
          check("busy_at_done", 32'(busy), 32'd1);
          check("ready_at_done", 32'(instr_ready), 32'd0);
`ifdef REGFILE_SEQUENCER_FLAGS_EN
          check("flag_c", 32'(flag_c), 32'(mon_e.v.fc));
          check("flag_z", 32'(flag_z), 32'(mon_e.v.fz));
`endif
        end
      end else if (cload) begin
        checks++;
        errors++;
        $display("FAIL cload_without_done: got cload=1 expected 0 (t=%0t)", $time);
      end
    end
  end

  // Offers an instruction and leaves instr_valid high so consecutive calls form a continuous stream.
  task automatic issue(input vec_t v, input bit push, input bit chk_gap);
    int   budget = 0;
    int   acc;
    exp_t e;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = v.ins;
    while (!instr_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got instr_ready=0 for %0d cycles expected 1", budget);
      return;
    end
    acc = cyc + 1;
    if (chk_gap) check("accept_gap", 32'(acc - prev_acc), 32'd4);
    prev_acc = acc;
    if (push) begin
      e.v   = v;
      e.acc = acc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_ready"}, 32'(instr_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cload"}, 32'(cload), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_asel"}, 32'(asel), 32'd0);
    check({tag, "_bsel"}, 32'(bsel), 32'd0);
    check({tag, "_csel"}, 32'(csel), 32'd0);
    check({tag, "_cin"}, 32'(cin), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    check({tag, "_flag_c"}, 32'(flag_c), 32'd0);
    check({tag, "_flag_z"}, 32'(flag_z), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;

    //           instr     cl  cs    cin    er  result chk fc fz
    vecs.push_back(mk(16'h73A5, 1, 4'd3, 8'hA5, 0, 8'hA5, 1, 0, 0)); // LDI r3,0xA5
    vecs.push_back(mk(16'h71F0, 1, 4'd1, 8'hF0, 0, 8'hF0, 1, 0, 0)); // LDI r1,0xF0
    vecs.push_back(mk(16'h7220, 1, 4'd2, 8'h20, 0, 8'h20, 1, 0, 0)); // LDI r2,0x20
    vecs.push_back(mk(16'h773C, 1, 4'd7, 8'h3C, 0, 8'h3C, 1, 0, 0)); // LDI r7,0x3C
    vecs.push_back(mk(16'h2412, 1, 4'd4, 8'h10, 0, 8'h10, 1, 1, 0)); // ADD r4,r1,r2 wraps
    vecs.push_back(mk(16'h3522, 1, 4'd5, 8'h00, 0, 8'h00, 1, 0, 1)); // SUB r5,r2,r2
    vecs.push_back(mk(16'h1650, 1, 4'd6, 8'h00, 0, 8'h00, 1, 0, 1)); // MOV r6,r5 back-to-back
    vecs.push_back(mk(16'h2912, 0, 4'd0, 8'h00, 1, 8'h00, 1, 0, 1)); // ADD with c=9: illegal
    vecs.push_back(mk(16'hF000, 0, 4'd0, 8'h00, 1, 8'h00, 1, 0, 1)); // opcode 15: illegal
    vecs.push_back(mk(16'h6031, 1, 4'd0, 8'h55, 0, 8'h55, 1, 0, 1)); // XOR r0,r3,r1
    vecs.push_back(mk(16'h4031, 1, 4'd0, 8'hA0, 0, 8'hA0, 1, 0, 1)); // AND r0,r3,r1
    vecs.push_back(mk(16'h5032, 1, 4'd0, 8'hA5, 0, 8'hA5, 1, 0, 1)); // OR  r0,r3,r2
    vecs.push_back(mk(16'h3421, 1, 4'd4, 8'h30, 0, 8'h30, 1, 1, 0)); // SUB r4,r2,r1 borrows
    vecs.push_back(mk(16'h0000, 0, 4'd0, 8'h00, 0, 8'h00, 0, 1, 0)); // NOP: no write, no err
    vecs.push_back(mk(16'h1080, 0, 4'd0, 8'h00, 1, 8'h00, 1, 1, 0)); // MOV from r8: illegal
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    vecs.push_back(mk(16'h8012, 1, 4'd0, 8'h11, 0, 8'h11, 1, 1, 0)); // ADC r0,r1,r2 with carry in
`else
    vecs.push_back(mk(16'h8012, 0, 4'd0, 8'h00, 1, 8'h00, 1, 1, 0)); // opcode 8: illegal here
`endif
    vecs.push_back(mk(16'h705A, 1, 4'd0, 8'h5A, 0, 8'h5A, 1, 1, 0)); // LDI r0,0x5A

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) issue(vecs[i], 1'b1, i > 0);
    @(negedge clk);
    instr_valid = 1'b0;
    drain();

    // Reset arrives mid-instruction: ADD r7,r1,r2 must be dropped without a write.
    issue(mk(16'h2712, 1, 4'd7, 8'h10, 0, 8'h10, 1, 1, 0), 1'b0, 1'b0);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("busy_in_exec", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    check("cload_during_reset", 32'(cload), 32'd0);
    rst = 1'b0;
    check("r7_kept", 32'(rf[7]), 32'h3C);

    issue(mk(16'h1670, 1, 4'd6, 8'h3C, 0, 8'h3C, 1, 0, 0), 1'b1, 1'b0); // MOV r6,r7
    @(negedge clk);
    instr_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
